// File: rtl/window_scheduler.sv
// window_scheduler
// Valid/ready front end for Image_Buffer. Each accepted pixel becomes a
// one-cycle buffer push. Row/column position is tracked so that only windows
// lying fully inside the frame and on the stride grid are flagged. While a
// flagged window waits for the consumer, the source is stalled so the
// buffer's kernel_out stays frozen.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no frame in progress, source held off
// S_PRIME  | filling the first KERNEL_SIZE-1 rows (no window possible yet)
// S_ACTIVE | full windows may be produced, runs to the last pixel
module window_scheduler #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 16,
    parameter int ROW_SIZE    = 5,
    parameter int COLUMN_SIZE = 5,
    parameter int STRIDE      = 1,
    localparam int OUT_W = (ROW_SIZE - KERNEL_SIZE) / STRIDE + 1,
    localparam int OUT_H = (COLUMN_SIZE - KERNEL_SIZE) / STRIDE + 1,
    localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
    input  logic                  clock,
    input  logic                  sreset_n,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  buf_valid,
    output logic [DATA_WIDTH-1:0] buf_data,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [RW-1:0]         win_row,
    output logic [CW-1:0]         win_col,
    output logic                  win_last,
    output logic                  busy
);

    localparam int COLW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int ROWW = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
    localparam int PHW  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [COLW-1:0] COL_LAST  = COLW'(ROW_SIZE - 1);
    localparam logic [COLW-1:0] COL_K1    = COLW'(KERNEL_SIZE - 1);
    localparam logic [ROWW-1:0] ROW_LAST  = ROWW'(COLUMN_SIZE - 1);
    localparam logic [ROWW-1:0] ROW_K1    = ROWW'(KERNEL_SIZE - 1);
    localparam logic [PHW-1:0]  PH_LAST   = PHW'(STRIDE - 1);
    localparam logic [RW-1:0]   OROW_LAST = RW'(OUT_H - 1);
    localparam logic [CW-1:0]   OCOL_LAST = CW'(OUT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_busy;
    logic [COLW-1:0] r_col;
    logic [ROWW-1:0] r_row;
    logic [PHW-1:0]  r_cph;
    logic [PHW-1:0]  r_rph;
    logic [CW-1:0]   r_ocol;
    logic [RW-1:0]   r_orow;
    logic            r_win_valid;
    logic [RW-1:0]   r_win_row;
    logic [CW-1:0]   r_win_col;
    logic            r_win_last;

    logic w_in_ready;
    logic w_push;
    logic w_col_last;
    logic w_row_last;
    logic w_frame_end;
    logic w_col_q;
    logic w_row_q;
    logic w_qual;

    // A pending window blocks new pushes unless it is consumed this cycle.
    assign w_in_ready  = (r_state != S_IDLE) && (!r_win_valid || win_ready);
    assign w_push      = in_valid && w_in_ready;
    assign w_col_last  = (r_col == COL_LAST);
    assign w_row_last  = (r_row == ROW_LAST);
    assign w_frame_end = w_push && w_col_last && w_row_last;
    assign w_col_q     = (r_col >= COL_K1) && (r_cph == '0);
    assign w_row_q     = (r_row >= ROW_K1) && (r_rph == '0);
    assign w_qual      = w_push && w_col_q && w_row_q;

    assign in_ready  = w_in_ready;
    assign buf_valid = w_push;
    assign buf_data  = in_data;
    assign win_valid = r_win_valid;
    assign win_row   = r_win_row;
    assign win_col   = r_win_col;
    assign win_last  = r_win_last;
    assign busy      = r_busy;

    // Frame sequencing; enable is only looked at in IDLE and at the last pixel.
    always_ff @(posedge clock or negedge sreset_n) begin
        if (!sreset_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state <= S_PRIME;
                        r_busy  <= 1'b1;
                    end
                end
                S_PRIME: begin
                    if (w_push && (r_row == ROW_K1) && (r_col == '0)) begin
                        r_state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_frame_end) begin
                        r_state <= enable ? S_PRIME : S_IDLE;
                        r_busy  <= enable;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Raster position, stride phases and output-map indices, advanced per push.
    // A phase only starts counting once its position has reached KERNEL_SIZE-1.
    always_ff @(posedge clock or negedge sreset_n) begin
        if (!sreset_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_cph  <= '0;
            r_rph  <= '0;
            r_ocol <= '0;
            r_orow <= '0;
        end else if (w_push) begin
            if (w_col_last) begin
                r_col  <= '0;
                r_cph  <= '0;
                r_ocol <= '0;
                if (w_row_last) begin
                    r_row  <= '0;
                    r_rph  <= '0;
                    r_orow <= '0;
                end else begin
                    r_row <= r_row + ROWW'(1);
                    if (r_row >= ROW_K1) begin
                        r_rph <= (r_rph == PH_LAST) ? '0 : r_rph + PHW'(1);
                    end else begin
                        r_rph <= '0;
                    end
                    if (w_row_q) begin
                        r_orow <= r_orow + RW'(1);
                    end
                end
            end else begin
                r_col <= r_col + COLW'(1);
                if (r_col >= COL_K1) begin
                    r_cph <= (r_cph == PH_LAST) ? '0 : r_cph + PHW'(1);
                end else begin
                    r_cph <= '0;
                end
                if (w_col_q) begin
                    r_ocol <= r_ocol + CW'(1);
                end
            end
        end
    end

    // Window flag: a new qualifying push wins over a consume in the same cycle.
    always_ff @(posedge clock or negedge sreset_n) begin
        if (!sreset_n) begin
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
            r_win_last  <= 1'b0;
        end else if (w_qual) begin
            r_win_valid <= 1'b1;
            r_win_row   <= r_orow;
            r_win_col   <= r_ocol;
            r_win_last  <= (r_orow == OROW_LAST) && (r_ocol == OCOL_LAST);
        end else if (r_win_valid && win_ready) begin
            r_win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_scheduler.sv
// Bench for window_scheduler: a stride-1 and a stride-2 instance share the
// stimulus; each is compared every cycle against a frame-level reference
// model that works from pixel index arithmetic.
module tb_window_scheduler;

    localparam int K  = 3;
    localparam int RS = 5;
    localparam int CS = 5;

    logic        clock;
    logic        sreset_n;
    logic        enable;
    logic        in_valid;
    logic        win_ready;
    logic [15:0] in_data;

    logic        rdy0, bv0, wv0, wl0, busy0;
    logic [15:0] bd0;
    logic [1:0]  wr0, wc0;
    logic        rdy1, bv1, wv1, wl1, busy1;
    logic [15:0] bd1;
    logic [0:0]  wr1, wc1;

    window_scheduler #(.KERNEL_SIZE(K), .DATA_WIDTH(16), .ROW_SIZE(RS),
                       .COLUMN_SIZE(CS), .STRIDE(1)) u_s1 (
        .clock(clock), .sreset_n(sreset_n), .enable(enable),
        .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .buf_valid(bv0), .buf_data(bd0), .win_valid(wv0), .win_ready(win_ready),
        .win_row(wr0), .win_col(wc0), .win_last(wl0), .busy(busy0)
    );

    window_scheduler #(.KERNEL_SIZE(K), .DATA_WIDTH(16), .ROW_SIZE(RS),
                       .COLUMN_SIZE(CS), .STRIDE(2)) u_s2 (
        .clock(clock), .sreset_n(sreset_n), .enable(enable),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .buf_valid(bv1), .buf_data(bd1), .win_valid(wv1), .win_ready(win_ready),
        .win_row(wr1), .win_col(wc1), .win_last(wl1), .busy(busy1)
    );

    logic        o_rdy[2], o_bv[2], o_wv[2], o_wl[2], o_busy[2];
    logic [15:0] o_bd[2];
    logic [3:0]  o_row[2], o_col[2];

    assign o_rdy[0] = rdy0;  assign o_rdy[1] = rdy1;
    assign o_bv[0]  = bv0;   assign o_bv[1]  = bv1;
    assign o_bd[0]  = bd0;   assign o_bd[1]  = bd1;
    assign o_wv[0]  = wv0;   assign o_wv[1]  = wv1;
    assign o_wl[0]  = wl0;   assign o_wl[1]  = wl1;
    assign o_busy[0] = busy0; assign o_busy[1] = busy1;
    assign o_row[0] = {2'b00, wr0}; assign o_row[1] = {3'b000, wr1};
    assign o_col[0] = {2'b00, wc0}; assign o_col[1] = {3'b000, wc1};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // reference model state, one slot per instance
    int m_stride[2] = '{1, 2};
    int m_ow[2]     = '{3, 2};
    int m_oh[2]     = '{3, 2};
    bit m_busy[2];
    int m_p[2];
    bit m_wv[2];
    int m_wr[2];
    int m_wc[2];
    bit m_wl[2];
    int m_frames[2];
    int cons[2];
    int k_next[2];
    bit exp_push[2];

    task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL dut%0d %s observed=%0h expected=%0h", d, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0; m_p[d] = 0; m_wv[d] = 1'b0; m_wr[d] = 0; m_wc[d] = 0;
            m_wl[d] = 1'b0; m_frames[d] = 0; cons[d] = 0; k_next[d] = 0; exp_push[d] = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk(d, {tag, "_in_ready"}, o_rdy[d], 0);
            chk(d, {tag, "_buf_valid"}, o_bv[d], 0);
            chk(d, {tag, "_win_valid"}, o_wv[d], 0);
            chk(d, {tag, "_win_row"}, o_row[d], 0);
            chk(d, {tag, "_win_col"}, o_col[d], 0);
            chk(d, {tag, "_win_last"}, o_wl[d], 0);
            chk(d, {tag, "_busy"}, o_busy[d], 0);
        end
    endtask

    // combinational outputs just before the edge, plus raster-order consumption
    task automatic pre_edge();
        bit er;
        for (int d = 0; d < 2; d++) begin
            er = m_busy[d] && (!m_wv[d] || win_ready);
            exp_push[d] = in_valid && er;
            chk(d, "in_ready", o_rdy[d], er);
            chk(d, "buf_valid", o_bv[d], exp_push[d]);
            chk(d, "buf_data", o_bd[d], in_data);
            if (o_wv[d] && win_ready) begin
                chk(d, "consume_row", o_row[d], k_next[d] / m_ow[d]);
                chk(d, "consume_col", o_col[d], k_next[d] % m_ow[d]);
                cons[d]++;
                k_next[d] = (k_next[d] + 1) % (m_ow[d] * m_oh[d]);
            end
        end
    endtask

    // advance the model by the edge just taken, then compare registered outputs
    task automatic post_edge();
        int row, col, s;
        bit q;
        for (int d = 0; d < 2; d++) begin
            s = m_stride[d];
            if (exp_push[d]) begin
                row = m_p[d] / RS;
                col = m_p[d] % RS;
                q = (row >= K-1) && (col >= K-1) && ((row-K+1) % s == 0) && ((col-K+1) % s == 0);
                if (q) begin
                    m_wv[d] = 1'b1;
                    m_wr[d] = (row-K+1) / s;
                    m_wc[d] = (col-K+1) / s;
                    m_wl[d] = (m_wr[d] == m_oh[d]-1) && (m_wc[d] == m_ow[d]-1);
                end else if (m_wv[d] && win_ready) begin
                    m_wv[d] = 1'b0;
                end
                m_p[d]++;
                if (m_p[d] == RS*CS) begin
                    m_p[d] = 0;
                    m_busy[d] = enable;
                    m_frames[d]++;
                end
            end else begin
                if (m_wv[d] && win_ready) m_wv[d] = 1'b0;
                if (!m_busy[d] && enable) m_busy[d] = 1'b1;
            end
            chk(d, "win_valid", o_wv[d], m_wv[d]);
            chk(d, "busy", o_busy[d], m_busy[d]);
            if (m_wv[d]) begin
                chk(d, "win_row", o_row[d], m_wr[d]);
                chk(d, "win_col", o_col[d], m_wc[d]);
                chk(d, "win_last", o_wl[d], m_wl[d]);
            end
        end
    endtask

    // one clock: inputs drawn at posedge+1, checks at negedge and posedge+1
    task automatic cycle(input int p_valid, input int p_ready);
        in_valid  = ($urandom_range(99) < p_valid);
        win_ready = ($urandom_range(99) < p_ready);
        in_data   = 16'($urandom);
        @(negedge clock);
        pre_edge();
        @(posedge clock);
        #1;
        post_edge();
    endtask

    initial begin
        bit found;
        model_reset();
        sreset_n  = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b1;
        win_ready = 1'b1;
        in_data   = 16'h0;
        #2 sreset_n = 1'b0;
        #2 chk_zero("reset");
        @(posedge clock);
        @(posedge clock);
        #1 sreset_n = 1'b1;

        // continuous stream, consumer always ready: one full frame plus one pixel
        repeat (27) cycle(100, 100);

        // stall the stride-1 consumer on window (1,1) for five cycles
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle(100, 100);
            if (o_wv[0] && o_row[0] == 4'd1 && o_col[0] == 4'd1) found = 1'b1;
        end
        chk(0, "stall_reach", found, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(100, 0);
            chk(0, "stall_row", o_row[0], 1);
            chk(0, "stall_col", o_col[0], 1);
        end
        cycle(100, 100);

        // random source gaps and consumer throttling over several frames
        repeat (300) cycle(70, 60);

        // drop enable mid-frame: frames finish, then everything goes idle and drains
        enable = 1'b0;
        repeat (150) cycle(70, 60);
        repeat (5) cycle(50, 100);
        for (int d = 0; d < 2; d++) begin
            chk(d, "idle_busy", o_busy[d], 0);
            chk(d, "idle_consumed", cons[d], m_frames[d] * m_ow[d] * m_oh[d]);
        end

        // re-enable and reset asynchronously while window after pixel 12 is pending
        enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle(100, 100);
            if (m_p[0] == 13 && o_wv[0]) found = 1'b1;
        end
        chk(0, "reset_reach", found, 1);
        sreset_n = 1'b0;
        #1;
        chk_zero("midreset");
        model_reset();
        #2 sreset_n = 1'b1;

        // one clean frame after reset, then back to idle
        repeat (2) cycle(100, 100);
        enable = 1'b0;
        repeat (40) cycle(100, 100);
        for (int d = 0; d < 2; d++) begin
            chk(d, "post_reset_windows", cons[d], m_ow[d] * m_oh[d]);
            chk(d, "post_reset_busy", o_busy[d], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
